// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock parametrised FIFO with occupancy flags and over/underflow pulses
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through read behaviour.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 64,
    parameter int AW         = $clog2(DEPTH),
    parameter int AF_THRESH  = DEPTH - 4,
    parameter int AE_THRESH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam logic [AW:0] ONE_C   = (AW+1)'(1);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_C    = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE_C    = (AW+1)'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count_next;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance uses the registered flags, so a read of an empty FIFO never bypasses a same-cycle write.
    assign wr_acc = wr_en && !full;
    assign rd_acc = rd_en && !empty;

    always_comb begin
        count_next = count;
        case ({wr_acc, rd_acc})
            2'b10:   count_next = count + ONE_C;
            2'b01:   count_next = count - ONE_C;
            default: count_next = count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count        <= count_next;
            full         <= (count_next == DEPTH_C);
            empty        <= (count_next == '0);
            almost_full  <= (count_next >= AF_C);
            almost_empty <= (count_next <= AE_C);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

`ifdef SYNC_FIFO_FWFT_EN
    // Head word is presented combinationally from the registered read pointer.
    assign rd_valid = !empty;
    assign rd_data  = empty ? '0 : mem[rd_ptr];
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_acc;
            if (rd_acc) begin
                rd_data <= mem[rd_ptr];
            end
        end
    end
`endif

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Single-clock, fully parametrised FIFO. It is the synchronous successor to the team's first-generation buffer.
- Adds correct full/empty at true DEPTH, a sized occupancy count, programmable almost-full/almost-empty thresholds, overflow/underflow reporting, and simultaneous read+write in one cycle.
- Sits between producer and consumer logic in the same clock domain: stream buffering, rate smoothing, back-pressure generation.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- DEPTH, 64, number of entries; power of 2, >= 2.
- AW, $clog2(DEPTH), address width; derived, do not override.
- AF_THRESH, DEPTH-4, almost_full asserts when count >= AF_THRESH; range 1..DEPTH.
- AE_THRESH, 4, almost_empty asserts when count <= AE_THRESH; range 0..DEPTH-1.

Ports:
- clk  in  1  single clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- wr_data  in  DATA_WIDTH  write data.
- rd_en  in  1  read request (pop acknowledge in FWFT mode).
- rd_data  out  DATA_WIDTH  read data.
- rd_valid  out  1  rd_data holds a valid popped or head word.
- count  out  AW+1  current occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_THRESH.
- almost_empty  out  1  count <= AE_THRESH.
- overflow  out  1  one-cycle pulse: write rejected.
- underflow  out  1  one-cycle pulse: read rejected.

Behaviour:
- Interface (already decided): one clock, clk; reset rst is synchronous and active-high.
- Reset values: wr_ptr=0, rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, rd_data=0, rd_valid=0, overflow=0, underflow=0. Memory is not reset.
- rst has priority over everything. wr_en/rd_en in a reset cycle are ignored, with no overflow/underflow pulse. Reset mid-operation discards all contents.
- Write accepted iff wr_en && !full, using full as sampled before the edge. mem[wr_ptr] <= wr_data; wr_ptr increments mod DEPTH.
- Read accepted iff rd_en && !empty, using empty as sampled before the edge. rd_ptr increments mod DEPTH.
- A write is not accepted when full, even if a read is accepted in the same cycle.
- Both accepted in one cycle: count unchanged; pointers both advance.
- Write only: count+1. Read only: count-1. Count never leaves 0..DEPTH.
- Pointers are AW bits and wrap naturally from DEPTH-1 to 0. Full/empty come from count, not pointer compare.
- full, empty, almost_full, almost_empty and count are registered. Each reflects the occupancy produced by the most recent edge, i.e. it is updated in the cycle after the accepting edge.
- overflow: registered one-cycle pulse the cycle after an edge with wr_en && full.
- underflow: registered one-cycle pulse the cycle after an edge with rd_en && empty.
- Standard mode, latency 1:
  - On an accepted read, rd_data <= mem[rd_ptr] and rd_valid <= 1 for exactly the next cycle.
  - rd_valid = 0 otherwise; rd_data holds its last value.
- Write-to-read hazard: a read of an empty FIFO is rejected even when a write occurs in the same cycle. No bypass.

Optional Feature:
- Macro: SYNC_FIFO_FWFT_EN.
- Defined (first-word-fall-through):
  - rd_valid = !empty. rd_data = mem[rd_ptr], the head word, whenever rd_valid = 1.
  - rd_en pops the head. The next word or rd_valid=0 appears the cycle after the pop.
  - A word written into an empty FIFO appears on rd_data with rd_valid=1 one cycle after the write edge.
  - Accept rules, count, flags and pulses are unchanged.
- Undefined: standard mode as above. No FWFT logic is synthesised.

Test Plan:
- Reset, then idle 3 cycles -> count=0, empty=1, almost_empty=1, full=0, rd_valid=0, rd_data=0.
- DEPTH=16, AF_THRESH=12: write 0x01..0x10 back-to-back -> almost_full rises the cycle after the 12th write; full=1 and count=16 after the 16th. A 17th write (0xAA) -> overflow pulses 1 cycle, count stays 16.
- From full: read 16 times -> rd_data sequence 0x01..0x10, each valid the cycle after its rd_en. Empty=1 after the last read. A 17th rd_en -> underflow pulse, rd_valid=0.
- Count=8, then wr_en && rd_en for 20 cycles -> count stays 8, pointers wrap past 15→0, data order preserved.
- Count=5, assert rst for 1 cycle together with wr_en=1 -> next cycle count=0, empty=1, no overflow/underflow. A subsequent write of 0x5A then read returns 0x5A.
- With SYNC_FIFO_FWFT_EN: write 0x3C into empty FIFO -> next cycle rd_valid=1, rd_data=0x3C with no rd_en. Pulse rd_en once -> next cycle rd_valid=0, empty=1.
